// File: rtl/display_scheduler_pkg.sv
// Shared definitions for the multiplexed hex display scheduler:
// parameter defaults, digit count, scan FSM encoding and source IDs.
package display_pkg;

    localparam int CLK_DIV_DEF      = 100000;
    localparam int BLANK_CYCLES_DEF = 1000;
    localparam int DWELL_FRAMES_DEF = 250;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/display_scheduler_scan_timer.sv
// Digit scan timing: a prescaler defines fixed-length digit slots, each
// split into a blanking phase followed by a show phase.
module scan_timer
    import display_pkg::*;
#(
    parameter int CLK_DIV      = CLK_DIV_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [DIGIT_W-1:0] digit_sel,
    output logic               blank,
    output logic               frame_tick
);

    localparam int               CNT_W      = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    scan_state_t        state_q, state_d;
    logic               slot_end;

    assign slot_end = (cnt_q == SLOT_LAST);
    assign cnt_d    = slot_end ? '0 : cnt_q + 1'b1;

    // Next state: leave BLANK after its last cycle, leave SHOW at slot end
    // and advance to the next digit.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        case (state_q)
            BLANK: if (cnt_q == BLANK_LAST) state_d = SHOW;
            SHOW: begin
                if (slot_end) begin
                    state_d = BLANK;
                    digit_d = digit_q + 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // Prescaler, FSM state and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= BLANK;
            digit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            digit_q <= digit_d;
        end
    end

    assign digit_sel  = digit_q;
    assign blank      = (state_q == BLANK);
    // High in the last cycle of the last digit: the edge ending it wraps
    // digit_sel to 0 and is the frame boundary.
    assign frame_tick = slot_end && (digit_q == DIGIT_W'(NUM_DIGITS - 1));

endmodule

// File: rtl/display_scheduler.sv
// Display scheduler: holds the latest word from two sources, picks which
// one is shown per frame (dwell-based alternation with lock), and flags
// overruns of unconsumed words.
module display_scheduler
    import display_pkg::*;
#(
    parameter int CLK_DIV      = CLK_DIV_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
    parameter int DWELL_FRAMES = DWELL_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        a_data,
    input  logic               a_valid,
    input  logic [15:0]        b_data,
    input  logic               b_valid,
    input  logic               src_lock,
    input  logic               ovr_clr,
    output logic [DIGIT_W-1:0] digit_sel,
    output logic [15:0]        disp_word,
    output logic               blank,
    output logic               src_cur,
    output logic               frame_tick,
    output logic [1:0]         ovr
);

    localparam int                DWELL_W    = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

    logic [1:0][15:0]   data_in;
    logic [1:0]         valid_in;
    logic [1:0][15:0]   hold_q, hold_d;
    logic [1:0]         has_q, has_d;
    logic [1:0]         pend_q, pend_d;
    logic [15:0]        disp_q, disp_d;
    logic               src_q, src_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         ovr_q, ovr_d;
    logic [1:0]         ovr_set;
    logic               sw, nsrc, ld;

    assign data_in[SRC_A]  = a_data;
    assign data_in[SRC_B]  = b_data;
    assign valid_in[SRC_A] = a_valid;
    assign valid_in[SRC_B] = b_valid;

    scan_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_sel  (digit_sel),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    // Frame-boundary arbitration and word capture; a frame load reads the
    // hold register before a same-cycle capture overwrites it.
    always_comb begin
        hold_d  = hold_q;
        has_d   = has_q;
        pend_d  = pend_q;
        disp_d  = disp_q;
        src_d   = src_q;
        dwell_d = dwell_q;
        ovr_set = '0;
        sw      = 1'b0;
        nsrc    = src_q;
        ld      = 1'b0;

        if (frame_tick) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                sw      = !src_lock && has_q[~src_q];
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
            nsrc  = src_q ^ sw;
            ld    = sw || pend_q[nsrc];
            src_d = nsrc;
            if (ld) begin
                disp_d       = hold_q[nsrc];
                pend_d[nsrc] = 1'b0;
            end
        end

        for (int x = 0; x < 2; x++) begin
            if (valid_in[x]) begin
                ovr_set[x] = pend_q[x] && !(ld && (nsrc == 1'(x)));
                hold_d[x]  = data_in[x];
                has_d[x]   = 1'b1;
                pend_d[x]  = 1'b1;
            end
        end

        // A new overrun wins over a coincident clear.
        ovr_d = (ovr_clr ? 2'b00 : ovr_q) | ovr_set;
    end

    // Source, display and overrun state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            has_q   <= '0;
            pend_q  <= '0;
            disp_q  <= '0;
            src_q   <= SRC_A;
            dwell_q <= '0;
            ovr_q   <= '0;
        end else begin
            hold_q  <= hold_d;
            has_q   <= has_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            src_q   <= src_d;
            dwell_q <= dwell_d;
            ovr_q   <= ovr_d;
        end
    end

    assign disp_word = disp_q;
    assign src_cur   = src_q;
    assign ovr       = ovr_q;

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter CLK_DIV, default 100000: clk cycles per digit slot.
REQ-002 Parameter BLANK_CYCLES, default 1000: blanking cycles at the start of each digit slot; 1 <= BLANK_CYCLES < CLK_DIV.
REQ-003 Parameter DWELL_FRAMES, default 250: frames spent on one source before a switch is considered; >= 1.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 a_data  in  16  source A word (accelerometer sample).
REQ-007 a_valid  in  1  one-cycle strobe; captures a_data.
REQ-008 b_data  in  16  source B word (status/debug).
REQ-009 b_valid  in  1  one-cycle strobe; captures b_data.
REQ-010 src_lock  in  1  while high, no source switch occurs.
REQ-011 ovr_clr  in  1  clears ovr.
REQ-012 digit_sel  out  2  digit index for the hex display decoder's Array input.
REQ-013 disp_word  out  16  word shown; feeds the decoder's Rx_Data input.
REQ-014 blank  out  1  high means all anodes must be forced off.
REQ-015 src_cur  out  1  source of disp_word: 0=A, 1=B.
REQ-016 frame_tick  out  1  one-cycle pulse at each frame boundary.
REQ-017 ovr  out  2  sticky overrun flags: bit0=A, bit1=B.

Function
REQ-018 A prescaler counts 0..CLK_DIV-1 and wraps, so each digit slot is exactly CLK_DIV cycles.
REQ-019 The FSM states are BLANK and SHOW: BLANK lasts BLANK_CYCLES cycles, then SHOW lasts CLK_DIV-BLANK_CYCLES cycles; on SHOW exit, digit_sel increments mod 4 and the FSM enters BLANK.
REQ-020 blank is 1 exactly while the FSM is in BLANK.
REQ-021 frame_tick pulses for one cycle in the cycle digit_sel wraps from 3 to 0.
REQ-022 Each source has a 16-bit hold register plus has_X and pend_X flags; X_valid loads hold_X and sets has_X and pend_X on the next edge.
REQ-023 If X_valid arrives while pend_X is set and no frame load consumes it in that cycle, ovr[X] sets; hold_X takes the new word.
REQ-024 If X_valid coincides with a frame load of X, disp_word takes the old hold_X, the new word becomes pending, and ovr is unchanged.
REQ-025 A dwell counter increments at each frame boundary.
REQ-026 At a frame boundary where dwell == DWELL_FRAMES-1: dwell clears; the source switches only if src_lock is 0 and has_other is 1.
REQ-027 At a frame boundary, disp_word loads the hold register of the next source if the source switched or that source's pend flag is set; the loaded pend flag then clears; otherwise disp_word holds its value.
REQ-028 disp_word, src_cur and digit_sel change only at slot and frame boundaries; no change occurs mid-SHOW.
REQ-029 ovr_clr clears ovr; if a set and a clear coincide, the set wins.

Reset
REQ-030 When rst_n is low: digit_sel=0, disp_word=0, blank=1, src_cur=0, frame_tick=0, ovr=0, holds=0, has/pend=0, dwell=0, prescaler=0, FSM=BLANK; this applies immediately, including mid-slot.
REQ-031 The first BLANK after rst_n deasserts lasts the full BLANK_CYCLES.

Structure
REQ-032 A shared package display_pkg holds: parameter defaults, NUM_DIGITS=4, the FSM state encoding (BLANK, SHOW), and source IDs SRC_A/SRC_B.
REQ-033 The prescaler and BLANK/SHOW FSM form sub-module scan_timer, with outputs digit_sel, blank and frame_tick; arbitration and holding registers live in the top level.

Verification (CLK_DIV=8, BLANK_CYCLES=2, DWELL_FRAMES=2)
REQ-034 Release reset -> blank=1 for 2 cycles and 0 for 6 cycles per slot; digit_sel steps 0,1,2,3 every 8 cycles; frame_tick every 32 cycles.
REQ-035 a_valid with 16'h1234 mid-frame -> disp_word stays 16'h0000 until the frame_tick cycle, then becomes 16'h1234 with src_cur=0.
REQ-036 a_valid 16'h1111 then 16'h2222 within one frame -> ovr=2'b01 and disp_word=16'h2222 at the next frame; ovr_clr -> ovr=0; ovr_clr coinciding with a new overrun -> ovr stays 1.
REQ-037 A=16'hAAAA and B=16'hBBBB written -> src_cur and disp_word alternate every 2 frames; src_lock=1 -> no change for 10 frames.
REQ-038 Only A written -> src_cur stays 0 indefinitely; a_valid coinciding with the frame-tick load -> old word shown, new word shown next frame, ovr=0.
REQ-039 rst_n pulsed low mid-SHOW on digit 2 -> all outputs take reset values in the same cycle; timing restarts per REQ-034.
